// File: rtl/sort_deserializer.sv
// sort_deserializer: collects p_nwords scalar words from a val/rdy stream and
// presents them as one parallel bundle to the sort pipeline. A new bundle's
// first word can be captured on the same edge the previous bundle leaves, so
// the input never stalls while the sorter keeps up.

// One storage slot of the bundle: a plain enabled word register.
module sort_deserializer_slot #(
  parameter int p_nbits = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               i_we,
  input  logic [p_nbits-1:0] i_d,
  output logic [p_nbits-1:0] o_q
);

  logic [p_nbits-1:0] r_q;

  // Slot register: cleared by reset, loaded when this slot is addressed.
  always_ff @(posedge clk) begin
    if (!reset_n)  r_q <= '0;
    else if (i_we) r_q <= i_d;
  end

  assign o_q = r_q;

endmodule

module sort_deserializer #(
  parameter int p_nbits  = 8,
  parameter int p_nwords = 4
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        in_val,
  output logic                        in_rdy,
  input  logic [p_nbits-1:0]          in_msg,
  output logic                        out_val,
  input  logic                        out_rdy,
  output logic [p_nwords*p_nbits-1:0] out_msg
);

  // A single-word bundle makes no sense for a pairwise sorter.
  if (p_nwords < 2) begin : g_param_chk
    $error("sort_deserializer: p_nwords must be >= 2");
  end

  // Guard keeps the counter at least one bit wide even for the bad case above.
  localparam int CNT_W = (p_nwords < 2) ? 1 : $clog2(p_nwords);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(p_nwords - 1);

  typedef enum logic {FILL = 1'b0, FULL = 1'b1} state_t;

  state_t                            r_state, w_state_nxt;
  logic [CNT_W-1:0]                  r_cnt, w_cnt_nxt;
  logic [CNT_W-1:0]                  w_wr_idx;
  logic                              w_in_fire, w_out_fire;
  logic [p_nwords-1:0][p_nbits-1:0]  w_word;

  // State and fill counter.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= FILL;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Handshake outputs and next-state. Both handshakes are forced low while
  // reset is asserted so nothing fires during the reset cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    in_rdy      = 1'b0;
    out_val     = 1'b0;
    w_wr_idx    = r_cnt;
    w_in_fire   = 1'b0;
    w_out_fire  = 1'b0;
    if (reset_n) begin
      case (r_state)
        FILL: begin
          in_rdy    = 1'b1;
          w_in_fire = in_val;
          if (w_in_fire) begin
            if (r_cnt == LAST) begin
              w_cnt_nxt   = '0;
              w_state_nxt = FULL;
            end else begin
              w_cnt_nxt = r_cnt + CNT_W'(1);
            end
          end
        end
        FULL: begin
          // Input is only taken when the bundle leaves on the same edge;
          // that word starts the next bundle in slot 0.
          out_val    = 1'b1;
          in_rdy     = out_rdy;
          w_out_fire = out_rdy;
          w_in_fire  = in_val & out_rdy;
          w_wr_idx   = '0;
          if (w_out_fire) begin
            w_state_nxt = FILL;
            w_cnt_nxt   = w_in_fire ? CNT_W'(1) : '0;
          end
        end
        default: begin
          w_state_nxt = FILL;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Word slots: slot k is written when an accepted word is addressed to it.
  for (genvar k = 0; k < p_nwords; k++) begin : g_slot
    sort_deserializer_slot #(.p_nbits(p_nbits)) u_slot (
      .clk     (clk),
      .reset_n (reset_n),
      .i_we    (w_in_fire && (w_wr_idx == CNT_W'(k))),
      .i_d     (in_msg),
      .o_q     (w_word[k])
    );
  end

  // Packed array order puts slot 0 in the LSBs of the bundle.
  assign out_msg = w_word;

endmodule

// File: tb/tb_sort_deserializer.sv
// Bench for sort_deserializer (8-bit words, 4 per bundle): a reset/first-bundle
// vector table, directed multi-cycle sequences, then random traffic checked
// against a queue-based reference of accepted words.
module tb_sort_deserializer;

  localparam int NB = 8;
  localparam int NW = 4;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              in_val = 1'b0;
  logic              in_rdy;
  logic [NB-1:0]     in_msg = '0;
  logic              out_val;
  logic              out_rdy = 1'b0;
  logic [NW*NB-1:0]  out_msg;

  int errors = 0;
  int checks = 0;

  logic [NB-1:0]    pend[$];   // accepted words not yet shipped
  logic [NW*NB-1:0] got[$];    // bundles seen leaving the DUT

  typedef struct {
    logic          rn;
    logic          iv;
    logic [NB-1:0] im;
    logic          ordy;
    logic          e_rdy;
    logic          e_val;
    logic [31:0]   e_msg;
  } vec_t;

  vec_t tab[9];

  sort_deserializer #(.p_nbits(NB), .p_nwords(NW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .in_val  (in_val),
    .in_rdy  (in_rdy),
    .in_msg  (in_msg),
    .out_val (out_val),
    .out_rdy (out_rdy),
    .out_msg (out_msg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One clock: drive inputs, check at negedge against the reference (and the
  // table row when given), then advance the reference at the posedge.
  task automatic tick(input logic rn, input logic iv, input logic [NB-1:0] im,
                      input logic ordy, input bit use_tab, input logic e_rdy,
                      input logic e_val, input logic [31:0] e_msg, input string tag);
    logic        m_rdy, m_val;
    logic [31:0] m_msg;
    reset_n = rn; in_val = iv; in_msg = im; out_rdy = ordy;
    @(negedge clk);
    m_val = rn && (pend.size() == NW);
    m_rdy = rn && ((pend.size() < NW) || ordy);
    m_msg = '0;
    if (m_val) for (int k = 0; k < NW; k++) m_msg[k*NB +: NB] = pend[k];
    chk({tag, " in_rdy"}, 32'(in_rdy), 32'(m_rdy));
    chk({tag, " out_val"}, 32'(out_val), 32'(m_val));
    if (m_val) chk({tag, " out_msg"}, out_msg, m_msg);
    if (use_tab) begin
      chk({tag, " tab in_rdy"}, 32'(in_rdy), 32'(e_rdy));
      chk({tag, " tab out_val"}, 32'(out_val), 32'(e_val));
      if (e_val) chk({tag, " tab out_msg"}, out_msg, e_msg);
    end
    if (out_val && out_rdy) got.push_back(out_msg);
    @(posedge clk);
    if (!rn) pend.delete();
    else begin
      if (m_val && ordy) repeat (NW) void'(pend.pop_front());
      if (iv && m_rdy) pend.push_back(im);
    end
    #1;
  endtask

  task automatic step(input logic rn, input logic iv, input logic [NB-1:0] im,
                      input logic ordy, input string tag);
    tick(rn, iv, im, ordy, 1'b0, 1'b0, 1'b0, '0, tag);
  endtask

  task automatic do_reset(input string tag);
    step(1'b0, 1'b0, '0, 1'b1, tag);
    step(1'b0, 1'b0, '0, 1'b1, tag);
    got.delete();
  endtask

  initial begin
    int stalls;
    logic [NB-1:0] w5[4];

    // Reset, then one back-to-back bundle 03,01,04,02.
    tab[0] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 32'h0};
    tab[1] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 32'h0};
    tab[2] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 32'h0};
    tab[3] = '{1'b1, 1'b1, 8'h03, 1'b1, 1'b1, 1'b0, 32'h0};
    tab[4] = '{1'b1, 1'b1, 8'h01, 1'b1, 1'b1, 1'b0, 32'h0};
    tab[5] = '{1'b1, 1'b1, 8'h04, 1'b1, 1'b1, 1'b0, 32'h0};
    tab[6] = '{1'b1, 1'b1, 8'h02, 1'b1, 1'b1, 1'b0, 32'h0};
    tab[7] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 32'h02040103};
    tab[8] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 32'h0};
    for (int i = 0; i < 9; i++)
      tick(tab[i].rn, tab[i].iv, tab[i].im, tab[i].ordy, 1'b1,
           tab[i].e_rdy, tab[i].e_val, tab[i].e_msg, $sformatf("tab[%0d]", i));

    // Backpressure: bundle held with FF waiting, then same-edge hand-off.
    do_reset("bp rst");
    step(1'b1, 1'b1, 8'h10, 1'b1, "bp fill");
    step(1'b1, 1'b1, 8'h20, 1'b1, "bp fill");
    step(1'b1, 1'b1, 8'h30, 1'b1, "bp fill");
    step(1'b1, 1'b1, 8'h40, 1'b1, "bp fill");
    for (int i = 0; i < 5; i++) begin
      reset_n = 1'b1; in_val = 1'b1; in_msg = 8'hFF; out_rdy = 1'b0;
      @(negedge clk);
      chk("bp hold in_rdy", 32'(in_rdy), 32'd0);
      chk("bp hold out_msg", out_msg, 32'h40302010);
      @(posedge clk); #1;
    end
    step(1'b1, 1'b1, 8'hFF, 1'b1, "bp handoff");
    step(1'b1, 1'b1, 8'h01, 1'b1, "bp next");
    step(1'b1, 1'b1, 8'h02, 1'b1, "bp next");
    step(1'b1, 1'b1, 8'h03, 1'b1, "bp next");
    step(1'b1, 1'b0, 8'h00, 1'b1, "bp drain");
    chk("bp bundle count", 32'(got.size()), 32'd2);
    if (got.size() == 2) begin
      chk("bp bundle0", got[0], 32'h40302010);
      chk("bp bundle1", got[1], 32'h030201FF);
    end

    // Full-rate streaming: no input stall across the bundle boundary.
    do_reset("st rst");
    stalls = 0;
    for (int i = 1; i <= 8; i++) begin
      reset_n = 1'b1; in_val = 1'b1; in_msg = 8'(i); out_rdy = 1'b1;
      #1;
      if (!in_rdy) stalls++;
      step(1'b1, 1'b1, 8'(i), 1'b1, "stream");
    end
    step(1'b1, 1'b0, 8'h00, 1'b1, "stream drain");
    chk("stream stalls", 32'(stalls), 32'd0);
    chk("stream bundle count", 32'(got.size()), 32'd2);
    if (got.size() == 2) begin
      chk("stream bundle0", got[0], 32'h04030201);
      chk("stream bundle1", got[1], 32'h08070605);
    end

    // Gapped input.
    do_reset("gap rst");
    w5 = '{8'h0A, 8'h0B, 8'h0C, 8'h0D};
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1, w5[i], 1'b1, "gap on");
      step(1'b1, 1'b0, 8'hEE, 1'b1, "gap off");
      step(1'b1, 1'b0, 8'hEE, 1'b1, "gap off");
    end
    chk("gap bundle count", 32'(got.size()), 32'd1);
    if (got.size() == 1) chk("gap bundle", got[0], 32'h0D0C0B0A);

    // Reset mid-bundle discards the partial words.
    do_reset("mid rst");
    step(1'b1, 1'b1, 8'h11, 1'b1, "mid pre");
    step(1'b1, 1'b1, 8'h22, 1'b1, "mid pre");
    step(1'b0, 1'b1, 8'h99, 1'b1, "mid pulse");
    step(1'b1, 1'b1, 8'h33, 1'b1, "mid post");
    step(1'b1, 1'b1, 8'h44, 1'b1, "mid post");
    step(1'b1, 1'b1, 8'h55, 1'b1, "mid post");
    step(1'b1, 1'b1, 8'h66, 1'b1, "mid post");
    step(1'b1, 1'b0, 8'h00, 1'b1, "mid drain");
    step(1'b1, 1'b0, 8'h00, 1'b1, "mid drain");
    chk("mid bundle count", 32'(got.size()), 32'd1);
    if (got.size() == 1) chk("mid bundle", got[0], 32'h66554433);

    // Random traffic with occasional reset against the reference queue.
    do_reset("rnd rst");
    for (int i = 0; i < 800; i++)
      step(($urandom_range(0, 59) != 0), 1'($urandom), 8'($urandom),
           ($urandom_range(0, 3) != 0), "rnd");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
